// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: data-bus slave between the CPU core and a word-wide synchronous SRAM.
// Checks request alignment, issues one SRAM access with byte enables and a fixed
// number of wait states, and returns right-aligned, zero-extended read data.
module mem_bus_ctrl #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              res,
    input  logic [31:0]       db_addr,
    input  logic [1:0]        db_accessType,
    input  logic [1:0]        db_memLen,
    input  logic [31:0]       db_dataOut,
    output logic [31:0]       db_dataIn,
    output logic              db_ready,
    output logic              db_error,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic [3:0]        sram_be,
    output logic              sram_ce,
    output logic              sram_we,
    input  logic [31:0]       sram_rdata
);

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_W    = 2'd2;
    localparam logic [1:0] LEN_B    = 2'd0;
    localparam logic [1:0] LEN_H    = 2'd1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, DONE, ERR} ctrlState_e;

    ctrlState_e  state;
    logic [3:0]  waitCnt;
    logic [1:0]  latOff;
    logic [1:0]  latLen;
    logic        latWrite;

    logic        reqMisaligned;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;

    // Address bits above the SRAM word address simply alias onto the same words.
    logic unusedAddrBits;
    assign unusedAddrBits = ^db_addr[31:ADDR_W+2];

    // Decode the incoming request: alignment, byte lanes and replicated store data.
    always_comb begin
        reqMisaligned = 1'b0;
        reqBe         = 4'b1111;
        reqWdata      = db_dataOut;
        case (db_memLen)
            LEN_B: begin
                reqBe    = 4'b0001 << db_addr[1:0];
                reqWdata = {4{db_dataOut[7:0]}};
            end
            LEN_H: begin
                reqMisaligned = db_addr[0];
                reqBe         = db_addr[1] ? 4'b1100 : 4'b0011;
                reqWdata      = {2{db_dataOut[15:0]}};
            end
            default: begin
                reqMisaligned = (db_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Pick the addressed lane out of the SRAM word, only while completing a read.
    always_comb begin
        db_dataIn = 32'd0;
        if (state == DONE && !latWrite) begin
            case (latLen)
                LEN_B:   db_dataIn = {24'd0, sram_rdata[{latOff, 3'b000} +: 8]};
                LEN_H:   db_dataIn = {16'd0, sram_rdata[{latOff[1], 4'b0000} +: 16]};
                default: db_dataIn = sram_rdata;
            endcase
        end
    end

    // Access sequencer; DONE and ERR accept a new request so back-to-back requests run without a bubble.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= IDLE;
            waitCnt    <= 4'd0;
            latOff     <= 2'd0;
            latLen     <= 2'd0;
            latWrite   <= 1'b0;
            db_ready   <= 1'b0;
            db_error   <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= 32'd0;
            sram_be    <= 4'd0;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
        end else begin
            db_ready <= 1'b0;
            db_error <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    sram_ce <= 1'b0;
                    sram_we <= 1'b0;
                    if (db_accessType != ACC_NONE) begin
                        latOff   <= db_addr[1:0];
                        latLen   <= db_memLen;
                        latWrite <= (db_accessType == ACC_W);
                        if (reqMisaligned) begin
                            state    <= ERR;
                            db_ready <= 1'b1;
                            db_error <= 1'b1;
                        end else begin
                            state      <= ACCESS;
                            sram_ce    <= 1'b1;
                            sram_we    <= (db_accessType == ACC_W);
                            sram_addr  <= db_addr[ADDR_W+1:2];
                            sram_be    <= reqBe;
                            sram_wdata <= reqWdata;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    waitCnt <= WAIT_CNT;
                    if (WAIT_CNT != 4'd0) begin
                        state <= WAIT;
                    end else begin
                        state    <= DONE;
                        sram_ce  <= 1'b0;
                        sram_we  <= 1'b0;
                        db_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1) begin
                        state    <= DONE;
                        sram_ce  <= 1'b0;
                        sram_we  <= 1'b0;
                        db_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: two controllers (one and zero wait states) share the request inputs;
// 'sel' chooses which one drives the SRAM model and is observed.
module tb_mem_bus_ctrl;

    localparam logic [1:0] NONE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] FX   = 2'd3;
    localparam logic [1:0] LB   = 2'd0;
    localparam logic [1:0] LH   = 2'd1;
    localparam logic [1:0] LW   = 2'd2;

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] addrIn;
    logic [1:0]  accessType;
    logic [1:0]  memLen;
    logic [31:0] dataOut;
    logic [31:0] sramRdata;
    logic        sel;

    logic [31:0] dataInA, dataInB, wdataA, wdataB;
    logic        readyA, readyB, errorA, errorB, ceA, ceB, weA, weB;
    logic [19:0] sramAddrA, sramAddrB;
    logic [3:0]  beA, beB;

    logic [31:0] obsDataIn, obsWdata;
    logic        obsReady, obsError, obsCe, obsWe;
    logic [19:0] obsAddr;
    logic [3:0]  obsBe;

    logic [31:0] sramMem [0:255];
    logic [7:0]  refMem [0:1023];

    int errors = 0;
    int checks = 0;

    int          rReadyAt, rReadyCnt, rCeCnt, rWeCnt, rLeaks, rUnstable;
    logic [19:0] rAddr;
    logic [3:0]  rBe;
    logic [31:0] rWdata, rData;
    logic        rErr;

    always #5 clk = ~clk;

    mem_bus_ctrl #(.WAIT_STATES(1), .ADDR_W(20)) dutA (
        .clk(clk), .res(res), .db_addr(addrIn), .db_accessType(accessType),
        .db_memLen(memLen), .db_dataOut(dataOut), .db_dataIn(dataInA),
        .db_ready(readyA), .db_error(errorA), .sram_addr(sramAddrA),
        .sram_wdata(wdataA), .sram_be(beA), .sram_ce(ceA), .sram_we(weA),
        .sram_rdata(sramRdata)
    );

    mem_bus_ctrl #(.WAIT_STATES(0), .ADDR_W(20)) dutB (
        .clk(clk), .res(res), .db_addr(addrIn), .db_accessType(accessType),
        .db_memLen(memLen), .db_dataOut(dataOut), .db_dataIn(dataInB),
        .db_ready(readyB), .db_error(errorB), .sram_addr(sramAddrB),
        .sram_wdata(wdataB), .sram_be(beB), .sram_ce(ceB), .sram_we(weB),
        .sram_rdata(sramRdata)
    );

    assign obsDataIn = sel ? dataInB : dataInA;
    assign obsReady  = sel ? readyB : readyA;
    assign obsError  = sel ? errorB : errorA;
    assign obsCe     = sel ? ceB : ceA;
    assign obsWe     = sel ? weB : weA;
    assign obsAddr   = sel ? sramAddrB : sramAddrA;
    assign obsBe     = sel ? beB : beA;
    assign obsWdata  = sel ? wdataB : wdataA;

    // Synchronous SRAM model: read data appears the cycle after a chip-enabled read.
    always @(posedge clk) begin
        if (obsCe === 1'b1) begin
            if (obsWe === 1'b1) begin
                for (int i = 0; i < 4; i++)
                    if (obsBe[i]) sramMem[obsAddr[7:0]][8*i +: 8] = obsWdata[8*i +: 8];
            end else begin
                sramRdata <= sramMem[obsAddr[7:0]];
            end
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int nBytes(input logic [1:0] len);
        return 1 << len;
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] addr, input logic [1:0] len);
        int base;
        logic [31:0] v;
        base = int'(addr % 1024);
        v = 32'd0;
        for (int j = 0; j < nBytes(len); j++)
            v = v | (32'(refMem[(base + j) % 1024]) << (8 * j));
        return v;
    endfunction

    task automatic modelWrite(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] data);
        int base;
        base = int'(addr % 1024);
        for (int j = 0; j < nBytes(len); j++)
            refMem[(base + j) % 1024] = data[8*j +: 8];
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        sramMem[idx] = val;
        for (int i = 0; i < 4; i++) refMem[4*idx + i] = val[8*i +: 8];
    endtask

    // Issue one request pulse and record what the selected controller does until ready has passed.
    task automatic runAccess(input logic [1:0] kind, input logic [1:0] len,
                             input logic [31:0] addr, input logic [31:0] data);
        rReadyAt = 0; rReadyCnt = 0; rCeCnt = 0; rWeCnt = 0; rLeaks = 0; rUnstable = 0;
        rAddr = '0; rBe = '0; rWdata = '0; rData = '0; rErr = 1'b0;
        accessType = kind; memLen = len; addrIn = addr; dataOut = data;
        @(negedge clk);
        accessType = NONE;
        for (int k = 1; k <= 40; k++) begin
            if (obsCe === 1'b1) begin
                if (rCeCnt == 0) begin
                    rAddr = obsAddr; rBe = obsBe; rWdata = obsWdata;
                end else if (obsAddr !== rAddr || obsBe !== rBe || obsWdata !== rWdata) begin
                    rUnstable++;
                end
                rCeCnt++;
                if (obsWe === 1'b1) rWeCnt++;
            end
            if (obsReady === 1'b1) begin
                rReadyCnt++;
                if (rReadyAt == 0) begin
                    rReadyAt = k; rData = obsDataIn; rErr = obsError;
                end
            end else if (obsDataIn !== 32'd0 || obsError !== 1'b0) begin
                rLeaks++;
            end
            if (rReadyAt != 0 && k > rReadyAt) break;
            @(negedge clk);
        end
    endtask

    // Outputs are zero while reset is held.
    task automatic test_reset();
        sel = 1'b0;
        res = 1'b1;
        #1 res = 1'b0;
        @(negedge clk);
        checks++;
        if ({obsReady, obsError, obsCe, obsWe} !== 4'b0000) begin
            errors++; $display("[TB] FAIL resetCtrl got %b want 0000", {obsReady, obsError, obsCe, obsWe});
        end
        checks++;
        if (obsDataIn !== 32'd0 || obsWdata !== 32'd0 || obsAddr !== 20'd0 || obsBe !== 4'd0) begin
            errors++; $display("[TB] FAIL resetData got dataIn=%0h wdata=%0h addr=%0h be=%b want 0", obsDataIn, obsWdata, obsAddr, obsBe);
        end
        @(negedge clk);
        res = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_word_read();
        sel = 1'b0;
        preload(4, 32'hDEADBEEF);
        runAccess(RD, LW, 32'h8000_0010, 32'd0);
        checks++; if (rAddr !== 20'd4) begin errors++; $display("[TB] FAIL wordReadAddr got %0h want 4", rAddr); end
        checks++; if (rCeCnt != 2) begin errors++; $display("[TB] FAIL wordReadCe got %0d want 2", rCeCnt); end
        checks++; if (rReadyAt != 3 || rReadyCnt != 1) begin errors++; $display("[TB] FAIL wordReadReady got at=%0d cnt=%0d want at=3 cnt=1", rReadyAt, rReadyCnt); end
        checks++; if (rData !== 32'hDEADBEEF || rErr !== 1'b0) begin errors++; $display("[TB] FAIL wordReadData got %0h err=%b want deadbeef err=0", rData, rErr); end
        checks++; if (rLeaks != 0) begin errors++; $display("[TB] FAIL wordReadLeak got %0d want 0", rLeaks); end
    endtask

    task automatic test_byte_store();
        sel = 1'b0;
        repeat (2) @(negedge clk);
        runAccess(WR, LB, 32'h0000_0023, 32'h0000_00A5);
        modelWrite(32'h0000_0023, LB, 32'h0000_00A5);
        checks++; if (rAddr !== 20'd8) begin errors++; $display("[TB] FAIL byteStoreAddr got %0h want 8", rAddr); end
        checks++; if (rBe !== 4'b1000) begin errors++; $display("[TB] FAIL byteStoreBe got %b want 1000", rBe); end
        checks++; if (rWdata !== 32'hA5A5A5A5) begin errors++; $display("[TB] FAIL byteStoreWdata got %0h want a5a5a5a5", rWdata); end
        checks++; if (rWeCnt != 2) begin errors++; $display("[TB] FAIL byteStoreWe got %0d want 2", rWeCnt); end
        checks++; if (rReadyAt != 3 || rData !== 32'd0) begin errors++; $display("[TB] FAIL byteStoreReady got at=%0d data=%0h want at=3 data=0", rReadyAt, rData); end
        checks++; if (sramMem[8] !== {refMem[35], refMem[34], refMem[33], refMem[32]}) begin
            errors++; $display("[TB] FAIL byteStoreMem got %0h want %0h", sramMem[8], {refMem[35], refMem[34], refMem[33], refMem[32]});
        end
    endtask

    task automatic test_half_load();
        sel = 1'b0;
        repeat (2) @(negedge clk);
        preload(1, 32'h80011234);
        runAccess(RD, LH, 32'h0000_0006, 32'd0);
        checks++; if (rBe !== 4'b1100) begin errors++; $display("[TB] FAIL halfLoadBe got %b want 1100", rBe); end
        checks++; if (rData !== 32'h0000_8001) begin errors++; $display("[TB] FAIL halfLoadData got %0h want 8001", rData); end
        checks++; if (rReadyAt != 3) begin errors++; $display("[TB] FAIL halfLoadReady got %0d want 3", rReadyAt); end
    endtask

    // Misaligned word load, then a fetch issued in the error cycle.
    task automatic test_misaligned();
        sel = 1'b0;
        repeat (2) @(negedge clk);
        accessType = RD; memLen = LW; addrIn = 32'h0000_0002;
        @(negedge clk);
        accessType = NONE;
        checks++;
        if (obsReady !== 1'b1 || obsError !== 1'b1 || obsCe !== 1'b0) begin
            errors++; $display("[TB] FAIL misalignErr got ready=%b err=%b ce=%b want 1 1 0", obsReady, obsError, obsCe);
        end
        accessType = FX; memLen = LW; addrIn = 32'h0000_0040;
        @(negedge clk);
        accessType = NONE;
        checks++;
        if (obsCe !== 1'b1 || obsReady !== 1'b0 || obsError !== 1'b0) begin
            errors++; $display("[TB] FAIL misalignNext got ce=%b ready=%b err=%b want 1 0 0", obsCe, obsReady, obsError);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (obsReady !== 1'b1 || obsDataIn !== refRead(32'h0000_0040, LW)) begin
            errors++; $display("[TB] FAIL misalignFetch got ready=%b data=%0h want 1 %0h", obsReady, obsDataIn, refRead(32'h0000_0040, LW));
        end
    endtask

    // Zero wait states: a fetch issued during DONE starts its access on the very next cycle.
    task automatic test_back_to_back();
        sel = 1'b1;
        repeat (3) @(negedge clk);
        accessType = RD; memLen = LW; addrIn = 32'h0000_0100;
        @(negedge clk);
        accessType = NONE;
        checks++; if (obsCe !== 1'b1) begin errors++; $display("[TB] FAIL b2bFirstCe got %b want 1", obsCe); end
        @(negedge clk);
        checks++;
        if (obsReady !== 1'b1 || obsDataIn !== refRead(32'h0000_0100, LW)) begin
            errors++; $display("[TB] FAIL b2bFirstReady got ready=%b data=%0h want 1 %0h", obsReady, obsDataIn, refRead(32'h0000_0100, LW));
        end
        accessType = FX; memLen = LW; addrIn = 32'h0000_0104;
        @(negedge clk);
        accessType = NONE;
        checks++;
        if (obsCe !== 1'b1 || obsReady !== 1'b0) begin
            errors++; $display("[TB] FAIL b2bSecondCe got ce=%b ready=%b want 1 0", obsCe, obsReady);
        end
        @(negedge clk);
        checks++;
        if (obsReady !== 1'b1 || obsDataIn !== refRead(32'h0000_0104, LW)) begin
            errors++; $display("[TB] FAIL b2bSecondReady got ready=%b data=%0h want 1 %0h", obsReady, obsDataIn, refRead(32'h0000_0104, LW));
        end
        repeat (2) @(negedge clk);
        sel = 1'b0;
    endtask

    // Reset asserted mid-store kills the SRAM cycle at once and the controller restarts cleanly.
    task automatic test_reset_during_store();
        int seen;
        seen = 0;
        sel = 1'b0;
        repeat (2) @(negedge clk);
        accessType = WR; memLen = LB; addrIn = 32'h0000_0031; dataOut = 32'h0000_005A;
        @(negedge clk);
        accessType = NONE;
        @(negedge clk);
        checks++; if (obsWe !== 1'b1 || obsCe !== 1'b1) begin errors++; $display("[TB] FAIL rstStoreActive got we=%b ce=%b want 1 1", obsWe, obsCe); end
        #2 res = 1'b0;
        #1;
        checks++;
        if ({obsWe, obsCe, obsReady, obsError} !== 4'b0000) begin
            errors++; $display("[TB] FAIL rstAsync got we/ce/ready/err=%b want 0000", {obsWe, obsCe, obsReady, obsError});
        end
        modelWrite(32'h0000_0031, LB, 32'h0000_005A);
        @(negedge clk);
        @(negedge clk);
        res = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (obsReady === 1'b1 || obsCe === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("[TB] FAIL rstIdle got %0d active cycles want 0", seen); end
        runAccess(RD, LB, 32'h0000_0031, 32'd0);
        checks++;
        if (rReadyAt != 3 || rData !== refRead(32'h0000_0031, LB)) begin
            errors++; $display("[TB] FAIL rstRestart got at=%0d data=%0h want at=3 data=%0h", rReadyAt, rData, refRead(32'h0000_0031, LB));
        end
    endtask

    // Random traffic on both controllers against the byte-level memory model.
    task automatic test_random();
        logic [1:0]  kind, len;
        logic [31:0] addr, data, expData, expW;
        logic [19:0] expA;
        logic [3:0]  expBe;
        int          ws, n;
        bit          mis, isWr;
        for (int t = 0; t < 150; t++) begin
            sel  = 1'($urandom_range(0, 1));
            ws   = sel ? 0 : 1;
            kind = 2'($urandom_range(1, 3));
            len  = 2'($urandom_range(0, 2));
            addr = $urandom;
            data = $urandom;
            n    = nBytes(len);
            isWr = (kind == WR);
            mis  = (addr % n) != 0;
            expA = 20'(addr >> 2);
            expBe = 4'(((1 << n) - 1) << (addr % 4));
            for (int i = 0; i < 4; i++) expW[8*i +: 8] = data[8*(i % n) +: 8];
            expData = isWr ? 32'd0 : refRead(addr, len);
            runAccess(kind, len, addr, data);
            if (mis) begin
                checks++;
                if (rReadyAt != 1 || rErr !== 1'b1 || rCeCnt != 0) begin
                    errors++; $display("[TB] FAIL randMisalign t=%0d got at=%0d err=%b ce=%0d want 1 1 0", t, rReadyAt, rErr, rCeCnt);
                end
            end else begin
                if (isWr) modelWrite(addr, len, data);
                checks++;
                if (rReadyAt != 2 + ws || rErr !== 1'b0) begin
                    errors++; $display("[TB] FAIL randTiming t=%0d got at=%0d err=%b want %0d 0", t, rReadyAt, rErr, 2 + ws);
                end
                checks++;
                if (rCeCnt != 1 + ws || rWeCnt != (isWr ? 1 + ws : 0)) begin
                    errors++; $display("[TB] FAIL randCe t=%0d got ce=%0d we=%0d want %0d %0d", t, rCeCnt, rWeCnt, 1 + ws, isWr ? 1 + ws : 0);
                end
                checks++;
                if (rAddr !== expA || rBe !== expBe) begin
                    errors++; $display("[TB] FAIL randAddrBe t=%0d got %0h %b want %0h %b", t, rAddr, rBe, expA, expBe);
                end
                if (isWr) begin
                    checks++;
                    if (rWdata !== expW) begin errors++; $display("[TB] FAIL randWdata t=%0d got %0h want %0h", t, rWdata, expW); end
                end
                checks++;
                if (rData !== expData) begin errors++; $display("[TB] FAIL randData t=%0d got %0h want %0h", t, rData, expData); end
            end
            checks++;
            if (rReadyCnt != 1 || rLeaks != 0 || rUnstable != 0) begin
                errors++; $display("[TB] FAIL randProtocol t=%0d got ready=%0d leaks=%0d unstable=%0d want 1 0 0", t, rReadyCnt, rLeaks, rUnstable);
            end
        end
        sel = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Run every scenario in order, then report.
    initial begin
        sel = 1'b0;
        accessType = NONE; memLen = LB; addrIn = 32'd0; dataOut = 32'd0;
        for (int w = 0; w < 256; w++) preload(w, $urandom);
        test_reset();
        test_word_read();
        test_byte_store();
        test_half_load();
        test_misaligned();
        test_back_to_back();
        test_reset_during_store();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
